// File: rtl/operand_seq_pkg.sv
// operand_seq_pkg: shared state encoding, mode constants and lane geometry for the operand sequencer
package operand_seq_pkg;
    typedef enum logic [1:0] {IDLE, PREFETCH, RUN, DONE} state_t;
    localparam logic MODE_ALEFT = 1'b0;
    localparam logic MODE_ARIGHT = 1'b1;
    localparam int A_LANES = 8;
    localparam int B_LANES = 4;
    // Beats per RAM word minus one: an operand eats 4 lanes per beat on its "wide" side, else 1
    function automatic logic [2:0] word_lim(input logic is_a, input logic mode);
        int lanes;
        lanes = is_a ? A_LANES : B_LANES;
        return 3'(((is_a ^ (mode == MODE_ARIGHT)) ? lanes >> 2 : lanes) - 1);
    endfunction
endpackage

// File: rtl/operand_seq_if.sv
// operand_seq_if: control inputs, RAM read ports and MAC beat controls of the operand sequencer
interface operand_seq_if #(parameter int ADDR_W = 12, parameter int CNT_W = 16);
    logic start, mode, stall;
    logic [CNT_W-1:0] n_inner, n_pass;
    logic [ADDR_W-1:0] a_base, b_base, a_addr, b_addr;
    logic a_rd, b_rd, start_pos, short_data_mode, short_bia_add, long_bia_add;
    logic mac_valid, last_beat, busy, done, err;
    modport master (
        output start, mode, stall, n_inner, n_pass, a_base, b_base,
        input a_rd, b_rd, a_addr, b_addr, start_pos, short_data_mode, short_bia_add, long_bia_add,
        input mac_valid, last_beat, busy, done, err
    );
    modport slave (
        input start, mode, stall, n_inner, n_pass, a_base, b_base,
        output a_rd, b_rd, a_addr, b_addr, start_pos, short_data_mode, short_bia_add, long_bia_add,
        output mac_valid, last_beat, busy, done, err
    );
endinterface

// File: rtl/opseq_addr_gen.sv
// opseq_addr_gen: word-slot counter and read-address register for one operand RAM
module opseq_addr_gen import operand_seq_pkg::*; #(
    parameter int ADDR_W = 12,
    parameter bit IS_A = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic              pre,
    input  logic              adv,
    input  logic              rewind,
    input  logic              fin,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base,
    output logic              rd,
    output logic [ADDR_W-1:0] addr
);
    logic [2:0] slot;
    logic [ADDR_W-1:0] base_q, ptr, nxt;
    logic word_end, run_rd;
    always_comb begin
        word_end = slot == word_lim(IS_A, mode);
        run_rd = adv && word_end && !fin;
        nxt = rewind ? base_q : ptr + 1'b1;
        rd = pre || run_rd;
        addr = run_rd ? nxt : ptr;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot <= '0;
            base_q <= '0;
            ptr <= '0;
        end else if (load) begin
            slot <= '0;
            base_q <= base;
            ptr <= base;
        end else if (adv) begin
            slot <= word_end ? 3'd0 : slot + 3'd1;
            if (run_rd) ptr <= nxt;
        end
    end
endmodule

// File: rtl/operand_seq.sv
// operand_seq: streams A/B operand words and emits one MAC beat per cycle.
// OPSEQ_PERF_EN adds saturating stall/beat performance counters.
module operand_seq import operand_seq_pkg::*; #(
    parameter int ADDR_W = 12,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rstn,
    operand_seq_if.slave bus
`ifdef OPSEQ_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_beat_cnt
`endif
);
    state_t state;
    logic mode_q;
    logic [CNT_W-1:0] n_inner_q, n_pass_q, k, pass;
    logic ok, accept, pre, beat, pass_end, fin;
    always_comb begin
        ok = bus.n_inner != '0 && bus.n_inner[2:0] == 3'd0 && bus.n_pass != '0;
        accept = state == IDLE && bus.start && ok;
        pre = state == PREFETCH;
        beat = state == RUN && !bus.stall;
        pass_end = k == n_inner_q - 1'b1;
        fin = pass_end && pass == n_pass_q - 1'b1;
    end
    assign bus.mac_valid = beat;
    assign bus.short_bia_add = beat;
    assign bus.long_bia_add = beat && mode_q == MODE_ALEFT;
    assign bus.last_beat = beat && pass_end;
    assign bus.short_data_mode = mode_q;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            mode_q <= 1'b0;
            n_inner_q <= '0;
            n_pass_q <= '0;
            k <= '0;
            pass <= '0;
            bus.start_pos <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            bus.start_pos <= 1'b0;
            bus.done <= 1'b0;
            bus.err <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    if (ok) begin
                        mode_q <= bus.mode;
                        n_inner_q <= bus.n_inner;
                        n_pass_q <= bus.n_pass;
                        k <= '0;
                        pass <= '0;
                        bus.start_pos <= 1'b1;
                        bus.busy <= 1'b1;
                        state <= PREFETCH;
                    end else bus.err <= 1'b1;
                end
                PREFETCH: state <= RUN;
                RUN: if (beat) begin
                    if (fin) begin
                        bus.done <= 1'b1;
                        state <= DONE;
                    end else if (pass_end) begin
                        k <= '0;
                        pass <= pass + 1'b1;
                    end else k <= k + 1'b1;
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // B rewinds to its base at each pass boundary; A runs linearly across passes
    opseq_addr_gen #(.ADDR_W(ADDR_W), .IS_A(1'b1)) u_a (
        .clk(clk), .rstn(rstn), .load(accept), .pre(pre), .adv(beat), .rewind(1'b0), .fin(fin),
        .mode(mode_q), .base(bus.a_base), .rd(bus.a_rd), .addr(bus.a_addr)
    );
    opseq_addr_gen #(.ADDR_W(ADDR_W), .IS_A(1'b0)) u_b (
        .clk(clk), .rstn(rstn), .load(accept), .pre(pre), .adv(beat), .rewind(pass_end), .fin(fin),
        .mode(mode_q), .base(bus.b_base), .rd(bus.b_rd), .addr(bus.b_addr)
    );
`ifdef OPSEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn || accept) begin
            perf_stall_cnt <= '0;
            perf_beat_cnt <= '0;
        end else begin
            if (state == RUN && bus.stall && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (beat && !(&perf_beat_cnt)) perf_beat_cnt <= perf_beat_cnt + 1'b1;
        end
    end
`endif
endmodule
